// File: rtl/data_mem_resp.sv
// Byte-wide data-memory responder with programmable wait states.
// Owns the storage array and answers one request at a time.
module data_mem_resp #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        rw_mem,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  wmem,
  output logic [7:0]  rmem,
  output logic        mem_ref,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       accept;

  logic                 lat_rw;
  logic                 lat_oor;
  logic [ADDR_BITS-1:0] lat_idx;
  logic [7:0]           lat_wd;

  logic                 in_oor;
  logic                 op_rw;
  logic                 op_oor;
  logic [ADDR_BITS-1:0] op_idx;
  logic [7:0]           op_wd;
  logic                 enter_ack;

  logic [7:0] mem [DEPTH];

  assign in_oor = |mem_addr[31:ADDR_BITS];

  // With zero wait states the op completes on its acceptance edge,
  // so it must be taken straight from the inputs.
  assign op_rw  = (state == IDLE) ? rw_mem : lat_rw;
  assign op_oor = (state == IDLE) ? in_oor : lat_oor;
  assign op_idx = (state == IDLE) ? mem_addr[ADDR_BITS-1:0] : lat_idx;
  assign op_wd  = (state == IDLE) ? wmem : lat_wd;

  assign enter_ack = (state_nxt == ACK);

  assign mem_ref  = (state == ACK);
  assign mem_busy = (state != IDLE);
  assign mem_err  = (state == ACK) && lat_oor;

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req) begin
          accept    = 1'b1;
          cnt_nxt   = WC;
          state_nxt = (WC == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, request latch and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      lat_rw  <= 1'b0;
      lat_oor <= 1'b0;
      lat_idx <= '0;
      lat_wd  <= 8'h00;
      rmem    <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_rw  <= rw_mem;
        lat_oor <= in_oor;
        lat_idx <= mem_addr[ADDR_BITS-1:0];
        lat_wd  <= wmem;
      end
      if (enter_ack && !op_rw) begin
        rmem <= op_oor ? 8'h00 : mem[op_idx];
      end
    end
  end

  // Storage array: commit a write on the edge entering ACK
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && op_rw && !op_oor) begin
      mem[op_idx] <= op_wd;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: transaction-level model plus directed checks.
// Instance 0 runs with 2 wait states, instance 1 with none.
module tb_data_mem_resp;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req  [NI];
  logic        rw   [NI];
  logic [31:0] addr [NI];
  logic [7:0]  wd   [NI];
  logic [7:0]  rmem [NI];
  logic        mref [NI];
  logic        busy [NI];
  logic        err  [NI];

  int  checks = 0;
  int  errors = 0;
  bit  run = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t",
               nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W = (g == 0) ? 2 : 0;

    data_mem_resp #(
      .ADDR_BITS(10),
      .WAIT_CYCLES(W)
    ) dut (
      .clk(clk),
      .rst(rst),
      .mem_req(req[g]),
      .rw_mem(rw[g]),
      .mem_addr(addr[g]),
      .wmem(wd[g]),
      .rmem(rmem[g]),
      .mem_ref(mref[g]),
      .mem_busy(busy[g]),
      .mem_err(err[g])
    );

    // Model: a request occupies W wait cycles then one ack cycle.
    bit          pend = 0;
    bit          ack = 0;
    bit          fin;
    bit          oor;
    int          left;
    logic        l_rw;
    logic [31:0] l_a;
    logic [7:0]  l_d;
    logic [7:0]  mm [int];
    logic        e_ref = 0;
    logic        e_err = 0;
    logic        e_busy = 0;
    logic [7:0]  e_rm = 0;
    bit          e_rk = 0;

    always @(posedge clk) begin
      if (rst) begin
        pend = 0; ack = 0;
        e_ref = 0; e_err = 0; e_busy = 0;
        e_rm = 8'h00; e_rk = 1;
      end else begin
        e_ref = 0; e_err = 0; fin = 0;
        if (ack) ack = 0;
        else if (pend) begin
          left--;
          if (left == 0) fin = 1;
        end else if (req[g]) begin
          l_rw = rw[g]; l_a = addr[g]; l_d = wd[g];
          pend = 1; left = W;
          if (W == 0) fin = 1;
        end
        if (fin) begin
          pend = 0; ack = 1; e_ref = 1;
          oor = (l_a >= 32'd1024);
          e_err = oor;
          if (l_rw) begin
            if (!oor) mm[int'(l_a)] = l_d;
          end else if (oor) begin
            e_rm = 8'h00; e_rk = 1;
          end else if (mm.exists(int'(l_a))) begin
            e_rm = mm[int'(l_a)]; e_rk = 1;
          end else begin
            e_rk = 0;
          end
        end
        e_busy = pend || ack;
      end
    end

    always @(negedge clk) begin
      if (run) begin
        chk("mem_ref", g, 32'(mref[g]), 32'(e_ref));
        chk("mem_busy", g, 32'(busy[g]), 32'(e_busy));
        chk("mem_err", g, 32'(err[g]), 32'(e_err));
        if (e_rk) chk("rmem", g, 32'(rmem[g]), 32'(e_rm));
      end
    end
  end

  task automatic do_op(input int g, input logic w, input logic [31:0] a,
                       input logic [7:0] d, output int lat);
    @(negedge clk);
    req[g] = 1'b1; rw[g] = w; addr[g] = a; wd[g] = d;
    @(negedge clk);
    req[g] = 1'b0;
    lat = 1;
    while (mref[g] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) chk("ack_timeout", g, 32'(lat), 32'd0);
  endtask

  task automatic rand_drive(input int g);
    int r;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req[g] = ($urandom_range(0, 1) == 1);
      rw[g]  = ($urandom_range(0, 1) == 1);
      wd[g]  = 8'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0: addr[g] = 32'h0000_0400;
        1: addr[g] = 32'hFFFF_FFFF;
        2: addr[g] = 32'h0000_03FF;
        default: addr[g] = 32'($urandom_range(0, 15));
      endcase
      if (g == 0) rst = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    req[g] = 1'b0;
    if (g == 0) rst = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    for (int g = 0; g < NI; g++) begin
      req[g] = 0; rw[g] = 0; addr[g] = 0; wd[g] = 0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    chk("rst_rmem", 0, 32'(rmem[0]), 32'h00);
    chk("rst_ref", 0, 32'(mref[0]), 32'h0);
    chk("rst_busy", 0, 32'(busy[0]), 32'h0);
    chk("rst_err", 0, 32'(err[0]), 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mref[0] || mref[1]) n++;
    end
    chk("idle_refs", 0, 32'(n), 32'd0);

    do_op(0, 1'b1, 32'h5, 8'hA5, lat);
    chk("wr_latency", 0, 32'(lat), 32'd3);
    chk("wr_err", 0, 32'(err[0]), 32'h0);
    do_op(0, 1'b0, 32'h5, 8'h00, lat);
    chk("rd_latency", 0, 32'(lat), 32'd3);
    chk("rd_data", 0, 32'(rmem[0]), 32'hA5);
    repeat (3) @(negedge clk);
    chk("rd_hold", 0, 32'(rmem[0]), 32'hA5);

    @(negedge clk);
    req[0] = 1; rw[0] = 1; addr[0] = 32'h6; wd[0] = 8'h11;
    @(negedge clk);
    wd[0] = 8'h22;
    @(negedge clk);
    req[0] = 0;
    lat = 0;
    while (mref[0] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mref[0]) n++;
    end
    chk("ignored_req_refs", 0, 32'(n), 32'd0);
    do_op(0, 1'b0, 32'h6, 8'h00, lat);
    chk("ignored_req_data", 0, 32'(rmem[0]), 32'h11);

    do_op(0, 1'b1, 32'h0, 8'h5C, lat);
    do_op(0, 1'b1, 32'h400, 8'h33, lat);
    chk("oor_wr_err", 0, 32'(err[0]), 32'h1);
    do_op(0, 1'b0, 32'h400, 8'h00, lat);
    chk("oor_rd_data", 0, 32'(rmem[0]), 32'h00);
    chk("oor_rd_err", 0, 32'(err[0]), 32'h1);
    do_op(0, 1'b0, 32'h0, 8'h00, lat);
    chk("alias_rd_data", 0, 32'(rmem[0]), 32'h5C);
    chk("alias_rd_err", 0, 32'(err[0]), 32'h0);

    do_op(0, 1'b1, 32'h9, 8'h10, lat);
    @(negedge clk);
    req[0] = 1; rw[0] = 1; addr[0] = 32'h9; wd[0] = 8'h77;
    @(negedge clk);
    req[0] = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ref", 0, 32'(mref[0]), 32'h0);
    chk("rst_mid_busy", 0, 32'(busy[0]), 32'h0);
    do_op(0, 1'b0, 32'h9, 8'h00, lat);
    chk("rst_mid_data", 0, 32'(rmem[0]), 32'h10);

    do_op(1, 1'b1, 32'h5, 8'hA5, lat);
    chk("w0_latency", 1, 32'(lat), 32'd1);
    @(negedge clk);
    req[1] = 1; rw[1] = 0; addr[1] = 32'h5;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("w0_busy_eq_ref", 1, 32'(busy[1]), 32'(mref[1]));
      if (mref[1]) begin
        n++;
        chk("w0_rd_data", 1, 32'(rmem[1]), 32'hA5);
      end
    end
    req[1] = 0;
    chk("w0_pulses", 1, 32'(n), 32'd5);

    fork
      rand_drive(0);
      rand_drive(1);
    join
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
